key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Conditions one active-low DE2 push button (KEY[n]) into clean control strobes.
//  Synchronises the asynchronous key and rejects contact bounce.
//  Emits single-cycle press/release pulses; o_pressed drives the random generator's i_start.
//  Sits between the board pin and the generator, in the same i_clk domain.
// PARAMETERS
//  SYNC_STAGES           2           synchroniser flops on i_key (>=2)
//  DEBOUNCE_CYCLES       1_000_000   stable samples required to accept a change (20 ms @ 50 MHz, >=1)
//  REPEAT_DELAY_CYCLES   25_000_000  hold time before first o_repeat (LONG_PRESS_EN only)
//  REPEAT_PERIOD_CYCLES  5_000_000   spacing of subsequent o_repeat pulses (LONG_PRESS_EN only)
// PORTS
//  i_clk       in   1  system clock, 50 MHz
//  i_rst       in   1  asynchronous reset, active-low
//  i_key       in   1  raw button, asynchronous, 0 = pressed
//  o_level     out  1  debounced level, 1 = pressed
//  o_pressed   out  1  one-cycle pulse on accepted press
//  o_released  out  1  one-cycle pulse on accepted release
//  o_repeat    out  1  one-cycle auto-repeat pulse while held (LONG_PRESS_EN)
// BEHAVIOUR
//  Interface: one clock i_clk; reset i_rst is asynchronous, active-low.
//  Reset: sync flops <= 1 (released), state UP, counters 0, all outputs 0.
//  key_s = ~(last sync stage); 1 = pressed. All outputs registered.
//  FSM, 4 states, 32-bit cnt:
//   UP:       o_level=0. key_s=1 -> ARM_DN, cnt<=0.
//   ARM_DN:   key_s=0 -> UP, no pulse. Else cnt++.
//             When cnt==DEBOUNCE_CYCLES-1 and key_s=1 -> DOWN, o_pressed=1 for that one cycle.
//   DOWN:     o_level=1. key_s=0 -> ARM_UP, cnt<=0.
//   ARM_UP:   o_level stays 1. key_s=1 -> DOWN, no pulse.
//             When cnt==DEBOUNCE_CYCLES-1 and key_s=0 -> UP, o_released=1.
//  Latency: key held low from edge t -> o_pressed and o_level rise at edge t+SYNC_STAGES+DEBOUNCE_CYCLES.
//   Release is symmetric.
//  Terminal-count cycle: decided on that cycle's key_s; a bounce there aborts.
//  o_pressed and o_released never both high; each press yields exactly one o_pressed.
//  Key held through reset release: seen as a new press, o_pressed after full latency.
//  Reset mid-operation: immediate return to reset values; no pending pulse survives.
//  cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
// CONFIGURATION
//  Macro LONG_PRESS_EN.
//  Defined:
//   - Repeat counter rcnt (32 bit) runs while state is DOWN.
//   - o_repeat pulses at REPEAT_DELAY_CYCLES after entering DOWN, then every REPEAT_PERIOD_CYCLES.
//   - rcnt holds during ARM_UP, resumes if the key bounces back to DOWN, clears on entering UP.
//   - o_repeat never coincides with o_pressed.
//  Undefined: rcnt absent, o_repeat tied 0 (port kept for a stable top level).
// STRUCTURE
//  key_debounce_pkg:
//   - typedef enum logic [1:0] {UP, ARM_DN, DOWN, ARM_UP} kd_state_t
//   - localparam KD_CNT_W = 32
//   - FAST_SIM-friendly default constants
//  Sub-module sync_ff #(STAGES, RST_VAL): n-flop synchroniser with async active-low reset.
//  FSM in one always_comb (_w signals) plus one always_ff (_r signals).
// TESTING (FAST_SIM: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
//  1 Reset, key low, release i_rst at edge 0 -> outputs 0 until edge 10; o_pressed pulse and o_level=1 at edge 10.
//  2 Clean press at edge 0, held 40, released at edge 40 -> o_pressed@10 only; o_released@50; o_level 1 over [10,50).
//  3 Bounce: low 5, high 1, low held from edge 6 -> exactly one o_pressed, at edge 16.
//  4 Glitch: low for 7 cycles then high -> no o_pressed, o_level stays 0.
//  5 LONG_PRESS_EN, hold 60 -> o_repeat at 30,35,...,60; macro undefined -> o_repeat always 0.
//  6 i_rst low at edge 5 of a press (ARM_DN) -> outputs 0 immediately; press restarts after reset release.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// FAST_SIM shrinks the default timing constants for short simulations.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        UP,
        ARM_DN,
        DOWN,
        ARM_UP
    } kd_state_t;

    localparam int KD_CNT_W = 32;

`ifdef FAST_SIM
    localparam int unsigned KD_DEF_SYNC_STAGES    = 2;
    localparam int unsigned KD_DEF_DEBOUNCE       = 8;
    localparam int unsigned KD_DEF_REPEAT_DELAY   = 20;
    localparam int unsigned KD_DEF_REPEAT_PERIOD  = 5;
`else
    localparam int unsigned KD_DEF_SYNC_STAGES    = 2;
    localparam int unsigned KD_DEF_DEBOUNCE       = 1_000_000;
    localparam int unsigned KD_DEF_REPEAT_DELAY   = 25_000_000;
    localparam int unsigned KD_DEF_REPEAT_PERIOD  = 5_000_000;
`endif

endpackage

// File: rtl/key_debounce_if.sv
// Button-side bundle: raw key in, debounced level and strobes out.
// slave: the debouncer (key in, strobes out); master: the driver/consumer.
interface key_debounce_if;

    logic i_key;
    logic o_level;
    logic o_pressed;
    logic o_released;
    logic o_repeat;

    modport slave (
        input  i_key,
        output o_level,
        output o_pressed,
        output o_released,
        output o_repeat
    );

    modport master (
        output i_key,
        input  o_level,
        input  o_pressed,
        input  o_released,
        input  o_repeat
    );

endinterface

// File: rtl/key_debounce_sync_ff.sv
// N-flop synchroniser with asynchronous active-low reset to RST_VAL.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low push button into a level plus press/release strobes.
// Ports: i_clk, i_rst (async, active-low), kd (key_debounce_if.slave).
// Macro LONG_PRESS_EN enables o_repeat auto-repeat; otherwise o_repeat is 0.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES          = KD_DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES      = KD_DEF_DEBOUNCE,
    parameter int unsigned REPEAT_DELAY_CYCLES  = KD_DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD_CYCLES = KD_DEF_REPEAT_PERIOD
) (
    input logic           i_clk,
    input logic           i_rst,
    key_debounce_if.slave kd
);

    localparam logic [KD_CNT_W-1:0] CNT_MAX =
        KD_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                key_sync;
    logic                key_s;
    kd_state_t           state_r, state_w;
    logic [KD_CNT_W-1:0] cnt_r, cnt_w;
    logic                level_r, level_w;
    logic                pressed_r, pressed_w;
    logic                released_r, released_w;

    // Sync flops reset to 1 so the key reads as released.
    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (i_clk),
        .rst_n (i_rst),
        .d     (kd.i_key),
        .q     (key_sync)
    );

    assign key_s = ~key_sync;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= UP;
            cnt_r      <= '0;
            level_r    <= 1'b0;
            pressed_r  <= 1'b0;
            released_r <= 1'b0;
        end else begin
            state_r    <= state_w;
            cnt_r      <= cnt_w;
            level_r    <= level_w;
            pressed_r  <= pressed_w;
            released_r <= released_w;
        end
    end

    always_comb begin
        state_w = state_r;
        cnt_w   = cnt_r;
        unique case (state_r)
            UP: begin
                if (key_s) begin
                    state_w = ARM_DN;
                    cnt_w   = '0;
                end
            end
            ARM_DN: begin
                if (!key_s) begin
                    state_w = UP;
                    cnt_w   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_w = DOWN;
                    cnt_w   = '0;
                end else begin
                    cnt_w = cnt_r + KD_CNT_W'(1);
                end
            end
            DOWN: begin
                if (!key_s) begin
                    state_w = ARM_UP;
                    cnt_w   = '0;
                end
            end
            ARM_UP: begin
                if (key_s) begin
                    state_w = DOWN;
                    cnt_w   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_w = UP;
                    cnt_w   = '0;
                end else begin
                    cnt_w = cnt_r + KD_CNT_W'(1);
                end
            end
            default: begin
                state_w = UP;
                cnt_w   = '0;
            end
        endcase
    end

    // Strobes fire on the terminal-count cycle, decided on that cycle's key_s.
    always_comb begin
        pressed_w  = (state_r == ARM_DN) && key_s && (cnt_r == CNT_MAX);
        released_w = (state_r == ARM_UP) && !key_s && (cnt_r == CNT_MAX);
        level_w    = (state_w == DOWN) || (state_w == ARM_UP);
    end

    assign kd.o_level    = level_r;
    assign kd.o_pressed  = pressed_r;
    assign kd.o_released = released_r;

`ifdef LONG_PRESS_EN
    localparam logic [KD_CNT_W-1:0] RDLY_MAX =
        KD_CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [KD_CNT_W-1:0] RPER_MAX =
        KD_CNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [KD_CNT_W-1:0] rcnt_r, rcnt_w;
    logic                rarm_r, rarm_w;
    logic                repeat_r, repeat_w;

    // rarm selects the period once the initial delay has elapsed.
    always_comb begin
        rcnt_w   = rcnt_r;
        rarm_w   = rarm_r;
        repeat_w = 1'b0;
        if (state_r == DOWN) begin
            if (rcnt_r == (rarm_r ? RPER_MAX : RDLY_MAX)) begin
                repeat_w = 1'b1;
                rcnt_w   = '0;
                rarm_w   = 1'b1;
            end else begin
                rcnt_w = rcnt_r + KD_CNT_W'(1);
            end
        end else if (state_w == UP) begin
            rcnt_w = '0;
            rarm_w = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rcnt_r   <= '0;
            rarm_r   <= 1'b0;
            repeat_r <= 1'b0;
        end else begin
            rcnt_r   <= rcnt_w;
            rarm_r   <= rarm_w;
            repeat_r <= repeat_w;
        end
    end

    assign kd.o_repeat = repeat_r;
`else
    assign kd.o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short timing constants.
// Edge n = n-th rising edge after the scenario starts.
module tb_key_debounce;

`ifdef LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic i_rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    key_debounce_if kif ();

    key_debounce #(
        .SYNC_STAGES          (2),
        .DEBOUNCE_CYCLES      (8),
        .REPEAT_DELAY_CYCLES  (20),
        .REPEAT_PERIOD_CYCLES (5)
    ) dut (
        .i_clk (clk),
        .i_rst (i_rst),
        .kd    (kif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic key_fn(input int id, input int n);
        case (id)
            2:       return (n < 40) ? 1'b0 : 1'b1;
            3:       return (n == 5) ? 1'b1 : 1'b0;
            4:       return (n < 7) ? 1'b0 : 1'b1;
            5:       return (n < 60) ? 1'b0 : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic expect_at(input int id, input int n,
                             output logic lv, output logic pr,
                             output logic rl, output logic rp);
        lv = 1'b0; pr = 1'b0; rl = 1'b0; rp = 1'b0;
        case (id)
            1: begin
                lv = (n >= 10);
                pr = (n == 10);
            end
            2: begin
                lv = (n >= 10) && (n < 50);
                pr = (n == 10);
                rl = (n == 50);
                rp = LP && (n == 30 || n == 35 || n == 40);
            end
            3: begin
                lv = (n >= 16);
                pr = (n == 16);
            end
            5: begin
                lv = (n >= 10) && (n < 70);
                pr = (n == 10);
                rl = (n == 70);
                rp = LP && (n >= 30) && (n <= 60) && (n % 5 == 0);
            end
            default: ;
        endcase
    endtask

    // Entered at a falling edge; leaves at a falling edge.
    task automatic run(input int id, input int len);
        logic lv, pr, rl, rp;
        for (int n = 0; n < len; n++) begin
            kif.i_key = key_fn(id, n);
            @(posedge clk);
            #1;
            expect_at(id, n, lv, pr, rl, rp);
            chk($sformatf("s%0d_e%0d_level", id, n), kif.o_level, lv);
            chk($sformatf("s%0d_e%0d_pressed", id, n), kif.o_pressed, pr);
            chk($sformatf("s%0d_e%0d_released", id, n), kif.o_released, rl);
            chk($sformatf("s%0d_e%0d_repeat", id, n), kif.o_repeat, rp);
            @(negedge clk);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"}, kif.o_level, 0);
        chk({tag, "_pressed"}, kif.o_pressed, 0);
        chk({tag, "_released"}, kif.o_released, 0);
        chk({tag, "_repeat"}, kif.o_repeat, 0);
    endtask

    task automatic do_reset(input logic key_during);
        i_rst = 1'b0;
        kif.i_key = key_during;
        #1;
        check_zero("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b1;
    endtask

    initial begin
        kif.i_key = 1'b1;
        do_reset(1'b1);

        do_reset(1'b0);
        run(1, 20);

        do_reset(1'b1);
        run(2, 60);

        do_reset(1'b1);
        run(3, 25);

        do_reset(1'b1);
        run(4, 25);

        do_reset(1'b1);
        run(5, 75);

        // Reset while arming a press, key kept low; press restarts.
        do_reset(1'b1);
        run(1, 6);
        i_rst = 1'b0;
        #1;
        check_zero("rst_arm_dn");
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        run(1, 20);

        // Reset while held down clears the level at once.
        i_rst = 1'b0;
        #1;
        check_zero("rst_down");

        // Reset on the terminal-count cycle drops the pending pulse.
        @(negedge clk);
        i_rst = 1'b1;
        run(1, 10);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
